// File: rtl/sar_search_controller_pkg.sv
// rtl/sar_search_controller_pkg.sv - shared types and helpers for the SAR search controller
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        DONE,
        ERR
    } state_t;

    localparam int MAX_WIDTH = 32;

    // Legal comparator flag patterns, packed as {gt, lt, eq}; anything else is a protocol error
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_LT = 3'b010;
    localparam logic [2:0] FLAG_EQ = 3'b001;

    function automatic logic [MAX_WIDTH-1:0] onehot_bit(input logic [31:0] idx);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sar_search_controller_if.sv
// rtl/sar_search_controller_if.sv - trial/response handshake between search engine and comparator
interface sar_search_controller_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] trial;
    logic             trial_valid;
    logic             cmp_valid;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output trial,
        output trial_valid,
        input  cmp_valid,
        input  gt,
        input  lt,
        input  eq
    );

    modport slave (
        input  trial,
        input  trial_valid,
        output cmp_valid,
        output gt,
        output lt,
        output eq
    );
endinterface

// File: rtl/sar_search_controller.sv
// rtl/sar_search_controller.sv - successive-approximation search driving a magnitude comparator
module sar_search_controller
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic                    i_START,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic [WIDTH-1:0]        o_RESULT,
    output logic                    o_FOUND,
    output logic                    o_ERR,
    sar_search_controller_if.master cmp
);

    localparam int IDXW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic [WIDTH-1:0] trial_w;
    logic [2:0]       flags;

    assign trial_w = acc_q | WIDTH'(onehot_bit(32'(idx_q)));
    assign flags   = {cmp.gt, cmp.lt, cmp.eq};

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            found_q  <= found_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        found_d  = found_q;
        case (state_q)
            IDLE, ERR: begin
                if (i_START) begin
                    acc_d    = '0;
                    idx_d    = IDXW'(WIDTH - 1);
                    result_d = '0;
                    found_d  = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (cmp.cmp_valid) begin
                    case (flags)
                        FLAG_EQ: begin
                            acc_d    = trial_w;
                            result_d = trial_w;
                            found_d  = 1'b1;
                            state_d  = DONE;
                        end
                        FLAG_LT, FLAG_GT: begin
                            if (flags == FLAG_LT) begin
                                acc_d = trial_w;
                            end
                            // Last bit resolved without EQ: only reachable for target 0 or exhausted search
                            if (idx_q == '0) begin
                                result_d = acc_d;
                                state_d  = DONE;
                            end else begin
                                idx_d   = idx_q - IDXW'(1);
                                state_d = GAP;
                            end
                        end
                        default: state_d = ERR;
                    endcase
                end
            end
            GAP:     state_d = REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmp.trial_valid = (state_q == REQ);
    assign cmp.trial       = (state_q == REQ) ? trial_w : '0;
    assign o_BUSY          = (state_q == REQ) || (state_q == GAP);
    assign o_DONE          = (state_q == DONE);
    assign o_ERR           = (state_q == ERR);
    assign o_RESULT        = result_q;
    assign o_FOUND         = found_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// tb/tb_sar_search_controller.sv - scoreboard bench with a comparator responder for the SAR search
module tb_sar_search_controller;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] res;
        logic         fnd;
        int           at;
    } done_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         busy, done, found, err;
    logic [W-1:0] result;

    logic [W-1:0] target = '0;
    int           delay = 0;
    int           bad_at = -1;
    int           n_resp = 0;
    int           wcnt = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           total = 0;
    int           bad = 0;

    logic [W-1:0] exp_trial[$];
    done_t        exp_done[$];

    sar_search_controller_if #(.WIDTH(W)) bus ();

    sar_search_controller #(.WIDTH(W)) dut (
        .i_CLK    (clk),
        .i_RST_N  (rst_n),
        .i_START  (start),
        .o_BUSY   (busy),
        .o_DONE   (done),
        .o_RESULT (result),
        .o_FOUND  (found),
        .o_ERR    (err),
        .cmp      (bus.master)
    );

    always #5 clk = ~clk;

    // Comparator responder: trial on operand A, target on operand B, optional wait and flag corruption
    logic corrupt;
    assign corrupt       = (n_resp == bad_at);
    assign bus.cmp_valid = bus.trial_valid && (wcnt == delay);
    assign bus.gt        = (bus.trial > target) | corrupt;
    assign bus.lt        = (bus.trial < target) | corrupt;
    assign bus.eq        = (bus.trial == target) & ~corrupt;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!bus.trial_valid) wcnt <= 0;
        else if (wcnt != delay) wcnt <= wcnt + 1;
        if (bus.trial_valid && bus.cmp_valid) n_resp <= n_resp + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.trial_valid) begin
                if (exp_trial.size() == 0) begin
                    chk("trial_expected", 0, 1);
                end else begin
                    chk("trial_value", int'(bus.trial), int'(exp_trial[0]));
                    if (bus.cmp_valid) void'(exp_trial.pop_front());
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("done_expected", 0, 1);
                end else begin
                    chk("done_result", int'(result), int'(exp_done[0].res));
                    chk("done_found", int'(found), int'(exp_done[0].fnd));
                    chk("done_cycle", cyc - start_cyc, exp_done[0].at);
                    void'(exp_done.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] tr, input int n, input logic [W-1:0] res,
                            input logic fnd, input int at);
        for (int i = 0; i < n; i++) exp_trial.push_back(tr[15-4*i -: 4]);
        exp_done.push_back('{res, fnd, at});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("err_clear_after_start", int'(err), 0);
    endtask

    task automatic wait_done(input logic [W-1:0] res, input logic fnd);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", int'(done), 1);
        @(posedge clk); #1;
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after_done", int'(busy), 0);
        chk("result_held", int'(result), int'(res));
        chk("found_held", int'(found), int'(fnd));
        chk("trials_left", exp_trial.size(), 0);
        chk("dones_left", exp_done.size(), 0);
    endtask

    task automatic run(input logic [W-1:0] tgt, input int dly, input logic [15:0] tr, input int n,
                       input logic [W-1:0] res, input logic fnd, input int at);
        target = tgt;
        delay  = dly;
        push_exp(tr, n, res, fnd, at);
        pulse_start();
        wait_done(res, fnd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_trial_valid", int'(bus.trial_valid), 0);
        chk("rst_trial", int'(bus.trial), 0);
        rst_n = 1'b1;

        run(4'd11, 0, 16'h8CAB, 4, 4'd11, 1'b1, 8);
        run(4'd0,  0, 16'h8421, 4, 4'd0,  1'b0, 8);
        run(4'd15, 0, 16'h8CEF, 4, 4'd15, 1'b1, 8);

        // Single-trial search; start during the DONE cycle must be dropped, one cycle later accepted
        target = 4'd8;
        delay  = 0;
        push_exp(16'h8000, 1, 4'd8, 1'b1, 2);
        pulse_start();
        @(posedge clk); #1;
        chk("b2b_done_cycle", int'(done), 1);
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", int'(busy), 0);
        start_cyc = cyc;
        push_exp(16'h8000, 1, 4'd8, 1'b1, 2);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_restart_busy", int'(busy), 1);
        wait_done(4'd8, 1'b1);

        // Slow responder with start toggling throughout the search
        target = 4'd5;
        delay  = 3;
        push_exp(16'h8465, 4, 4'd5, 1'b1, 20);
        pulse_start();
        repeat (6) begin
            @(posedge clk); #1;
            start = ~start;
        end
        start = 1'b0;
        wait_done(4'd5, 1'b1);

        // Corrupted flags on the second trial
        target = 4'd9;
        delay  = 0;
        bad_at = n_resp + 1;
        exp_trial.push_back(4'd8);
        exp_trial.push_back(4'd12);
        pulse_start();
        n = 0;
        while (!err && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("err_seen", int'(err), 1);
        chk("err_busy", int'(busy), 0);
        chk("err_trial_valid", int'(bus.trial_valid), 0);
        chk("err_cycle", cyc - start_cyc, 4);
        repeat (3) @(negedge clk);
        chk("err_held", int'(err), 1);
        chk("err_trials_left", exp_trial.size(), 0);
        bad_at = -1;
        run(4'd3, 0, 16'h8423, 4, 4'd3, 1'b1, 8);

        // Reset while trial 12 is outstanding
        target = 4'd11;
        delay  = 3;
        exp_trial.push_back(4'd8);
        exp_trial.push_back(4'd12);
        pulse_start();
        n = 0;
        while (!(bus.trial_valid && bus.trial == 4'd12) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_trial_12", int'(bus.trial), 12);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_trial_valid", int'(bus.trial_valid), 0);
        chk("mid_rst_trial", int'(bus.trial), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_found", int'(found), 0);
        chk("mid_rst_pending", exp_trial.size(), 1);
        exp_trial.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", int'(busy), 0);

        run(4'd15, 0, 16'h8CEF, 4, 4'd15, 1'b1, 8);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
